pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage core. Watches the decode stage's source/destination
//  fields, tracks the load currently in EX, and issues per-stage stall bits and a flush pulse.
//  Arbitrates three stall/flush sources: load-use hazard, multi-cycle EX request, flush.
//  Reads the ID-stage decode outputs; stall_o feeds every pipeline register and the PC.
// PARAMETERS
//  MAX_EX_STALL  16  consecutive ex_stallreq_i cycles before ex_timeout_o sets (>=2)
//  FLUSH_CYC     1   cycles flush_o stays high per accepted flush (1..7)
//  STALL_CNT_W   16  width of saturating stall-cycle counter
// PORTS
//  clk             in   1            system clock, all state on rising edge
//  rst             in   1            synchronous, active-low reset
//  id_reg1_read_i  in   1            ID reads source 1 from regfile
//  id_reg1_addr_i  in   5            ID source 1 address
//  id_reg2_read_i  in   1            ID reads source 2 from regfile
//  id_reg2_addr_i  in   5            ID source 2 address
//  id_wd_i         in   5            ID destination address
//  id_wreg_i       in   1            ID instruction writes wd
//  id_is_load_i    in   1            ID instruction is a load
//  ex_stallreq_i   in   1            EX busy with multi-cycle op (divider)
//  flush_req_i     in   1            exception/redirect flush request
//  stall_o         out  6            [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; 1 = hold
//  flush_o         out  1            clear IF/ID/EX/MEM pipeline registers
//  ex_timeout_o    out  1            sticky: EX stall exceeded MAX_EX_STALL
//  stall_cnt_o     out  STALL_CNT_W  cycles with stall_o != 0, saturating
// BEHAVIOUR
//  Reset (rst==0 at edge): state=RUN, ld_v=0, ld_wd=0, ex_cnt=0, flush_cnt=0, stall_cnt_o=0,
//   ex_timeout_o=0. stall_o=0 and flush_o=0 while rst==0 (combinationally forced); reset mid-
//   stall or mid-flush abandons it, no residual pulse.
//  Load tracker (ld_v, ld_wd = load in EX):
//   - ID->EX advance (stall_o[2]=0): ld_v<=id_is_load_i&id_wreg_i&(id_wd_i!=0); ld_wd<=id_wd_i.
//   - Bubble (stall_o[2]=1, stall_o[3]=0): ld_v<=0.   EX held (stall_o[3]=1): hold.
//   - state FLUSH: ld_v<=0.
//  load_use = ld_v & ((id_reg1_read_i & id_reg1_addr_i==ld_wd) |
//                     (id_reg2_read_i & id_reg2_addr_i==ld_wd)); r0 never hazards.
//  stall_o (combinational, same cycle as inputs), priority high->low:
//   state FLUSH -> 6'b000000 (all requests ignored);
//   ex_stallreq_i -> 6'b001111;  load_use -> 6'b000111;  else 6'b000000.
//  FSM states RUN, EXSTALL, FLUSH:
//   RUN:     flush_req_i -> FLUSH (flush_cnt=0); else ex_stallreq_i -> EXSTALL (ex_cnt=1).
//   EXSTALL: flush_req_i -> FLUSH; ex_stallreq_i=0 -> RUN (ex_cnt=0); else ex_cnt+=1,
//            saturating at MAX_EX_STALL.
//   FLUSH:   flush_o=1; flush_cnt+=1; flush_cnt==FLUSH_CYC-1 -> RUN. flush_req_i re-asserted
//            during FLUSH is absorbed (no extension).
//   flush_o latency: 1 cycle after flush_req_i sampled; lasts exactly FLUSH_CYC cycles.
//  Timeout: ex_timeout_o<=1 at the edge where ex_cnt reaches MAX_EX_STALL with ex_stallreq_i
//   still high (visible after MAX_EX_STALL high cycles); cleared only by reset or by
//   entering FLUSH. Does not itself alter stall_o.
//  stall_cnt_o: +1 at each edge where stall_o!=0; holds at all-ones.
//  Simultaneous flush_req_i + ex_stallreq_i in RUN: stall_o=001111 that cycle, then FLUSH.
// TESTING
//  T1 load r3 advances to EX; next ID reads r3 on port 1 -> stall_o=000111 one cycle, then 0;
//     stall_cnt_o=1.
//  T2 load to r0, then ID reads r0 on both ports -> stall_o stays 0.
//  T3 load r5 in EX, ex_stallreq_i high 5 cycles while ID reads r5 on port 2 -> 001111 x5,
//     then 000111 x1, then 0; stall_cnt_o=6.
//  T4 ex_stallreq_i held 20 cycles, MAX_EX_STALL=16 -> ex_timeout_o=1 after cycle 16 and
//     sticky; flush_req_i pulse clears it the next cycle.
//  T5 FLUSH_CYC=3, load r2 in EX, flush_req_i 1 cycle -> flush_o=1 x3 from next cycle,
//     stall_o=0 throughout, later ID read of r2 gives no stall.
//  T6 rst=0 in cycle 3 of EXSTALL with ex_stallreq_i high -> stall_o=0 during reset; after
//     edge state=RUN, counters and ex_timeout_o 0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the ID/EX stages and the pipeline sequencer:
// decode hazard fields and stall/flush requests in, per-stage stall bits and flush out.
interface pipe_ctrl_if #(
   parameter int STALL_CNT_W = 16
);
   logic                   id_reg1_read_i;
   logic [4:0]             id_reg1_addr_i;
   logic                   id_reg2_read_i;
   logic [4:0]             id_reg2_addr_i;
   logic [4:0]             id_wd_i;
   logic                   id_wreg_i;
   logic                   id_is_load_i;
   logic                   ex_stallreq_i;
   logic                   flush_req_i;
   logic [5:0]             stall_o;
   logic                   flush_o;
   logic                   ex_timeout_o;
   logic [STALL_CNT_W-1:0] stall_cnt_o;

   modport master (
      output id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i, id_reg2_addr_i,
      output id_wd_i, id_wreg_i, id_is_load_i, ex_stallreq_i, flush_req_i,
      input  stall_o, flush_o, ex_timeout_o, stall_cnt_o
   );

   modport slave (
      input  id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i, id_reg2_addr_i,
      input  id_wd_i, id_wreg_i, id_is_load_i, ex_stallreq_i, flush_req_i,
      output stall_o, flush_o, ex_timeout_o, stall_cnt_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use and multi-cycle EX stalls,
// fixed-length flush, EX stall timeout and a saturating stall-cycle counter.
module pipe_ctrl #(
   parameter int MAX_EX_STALL = 16,
   parameter int FLUSH_CYC    = 1,
   parameter int STALL_CNT_W  = 16
) (
   input  logic       clk,
   input  logic       rst,
   pipe_ctrl_if.slave bus
);
   localparam int                     EXC_W      = $clog2(MAX_EX_STALL + 1);
   localparam logic [EXC_W-1:0]       EX_MAX     = EXC_W'(MAX_EX_STALL);
   localparam logic [EXC_W-1:0]       EX_ONE     = EXC_W'(1);
   localparam logic [EXC_W-1:0]       EX_ZERO    = EXC_W'(0);
   localparam logic [2:0]             FL_LAST    = 3'(FLUSH_CYC - 1);
   localparam logic [5:0]             STALL_EX   = 6'b001111;
   localparam logic [5:0]             STALL_LU   = 6'b000111;
   localparam logic [5:0]             STALL_NONE = 6'b000000;
   localparam logic [STALL_CNT_W-1:0] CNT_SAT    = {STALL_CNT_W{1'b1}};
   localparam logic [STALL_CNT_W-1:0] CNT_ONE    = STALL_CNT_W'(1);
   localparam logic [STALL_CNT_W-1:0] CNT_ZERO   = STALL_CNT_W'(0);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_EXSTALL = 2'd1,
      ST_FLUSH   = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [EXC_W-1:0]       r_ex_cnt;
   logic [EXC_W-1:0]       w_ex_cnt_nxt;
   logic [2:0]             r_flush_cnt;
   logic [2:0]             w_flush_cnt_nxt;
   logic                   r_ld_v;
   logic [4:0]             r_ld_wd;
   logic                   r_timeout;
   logic [STALL_CNT_W-1:0] r_stall_cnt;
   logic                   w_load_use;
   logic                   w_enter_flush;
   logic                   w_set_timeout;
   logic [5:0]             w_stall;

   // Load-use hazard: the load in EX writes a register the ID instruction reads.
   // r0 loads never set r_ld_v, so r0 can never hazard.
   always_comb begin
      w_load_use = 1'b0;
      if (r_ld_v) begin
         w_load_use = (bus.id_reg1_read_i && (bus.id_reg1_addr_i == r_ld_wd)) ||
                      (bus.id_reg2_read_i && (bus.id_reg2_addr_i == r_ld_wd));
      end else begin
         w_load_use = 1'b0;
      end
   end

   // Stall arbitration: reset and flush override every request.
   always_comb begin
      w_stall = STALL_NONE;
      if (!rst) begin
         w_stall = STALL_NONE;
      end else if (r_state == ST_FLUSH) begin
         w_stall = STALL_NONE;
      end else if (bus.ex_stallreq_i) begin
         w_stall = STALL_EX;
      end else if (w_load_use) begin
         w_stall = STALL_LU;
      end else begin
         w_stall = STALL_NONE;
      end
   end

   // Next-state and counter logic for RUN / EXSTALL / FLUSH.
   always_comb begin
      w_state_nxt     = r_state;
      w_ex_cnt_nxt    = r_ex_cnt;
      w_flush_cnt_nxt = r_flush_cnt;
      case (r_state)
         ST_RUN: begin
            if (bus.flush_req_i) begin
               w_state_nxt     = ST_FLUSH;
               w_ex_cnt_nxt    = EX_ZERO;
               w_flush_cnt_nxt = 3'd0;
            end else if (bus.ex_stallreq_i) begin
               w_state_nxt  = ST_EXSTALL;
               w_ex_cnt_nxt = EX_ONE;
            end else begin
               w_state_nxt  = ST_RUN;
               w_ex_cnt_nxt = EX_ZERO;
            end
         end
         ST_EXSTALL: begin
            if (bus.flush_req_i) begin
               w_state_nxt     = ST_FLUSH;
               w_ex_cnt_nxt    = EX_ZERO;
               w_flush_cnt_nxt = 3'd0;
            end else if (!bus.ex_stallreq_i) begin
               w_state_nxt  = ST_RUN;
               w_ex_cnt_nxt = EX_ZERO;
            end else if (r_ex_cnt != EX_MAX) begin
               w_ex_cnt_nxt = r_ex_cnt + EX_ONE;
            end else begin
               w_ex_cnt_nxt = r_ex_cnt;
            end
         end
         ST_FLUSH: begin
            // Flush requests arriving here are absorbed; the length is fixed.
            w_ex_cnt_nxt = EX_ZERO;
            if (r_flush_cnt == FL_LAST) begin
               w_state_nxt     = ST_RUN;
               w_flush_cnt_nxt = 3'd0;
            end else begin
               w_flush_cnt_nxt = r_flush_cnt + 3'd1;
            end
         end
         default: begin
            w_state_nxt     = ST_RUN;
            w_ex_cnt_nxt    = EX_ZERO;
            w_flush_cnt_nxt = 3'd0;
         end
      endcase
   end

   assign w_enter_flush = (r_state != ST_FLUSH) && (w_state_nxt == ST_FLUSH);
   assign w_set_timeout = (w_state_nxt == ST_EXSTALL) && (w_ex_cnt_nxt == EX_MAX);

   // FSM state and counter registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_RUN;
         r_ex_cnt    <= EX_ZERO;
         r_flush_cnt <= 3'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_ex_cnt    <= w_ex_cnt_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
      end
   end

   // Tracks the load sitting in EX: follows ID->EX advance, bubbles and holds.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ld_v  <= 1'b0;
         r_ld_wd <= 5'd0;
      end else if (r_state == ST_FLUSH) begin
         r_ld_v  <= 1'b0;
      end else if (!w_stall[2]) begin
         r_ld_v  <= bus.id_is_load_i && bus.id_wreg_i && (bus.id_wd_i != 5'd0);
         r_ld_wd <= bus.id_wd_i;
      end else if (!w_stall[3]) begin
         r_ld_v  <= 1'b0;
      end else begin
         r_ld_v  <= r_ld_v;
      end
   end

   // Sticky EX timeout and saturating stall-cycle counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_timeout   <= 1'b0;
         r_stall_cnt <= CNT_ZERO;
      end else begin
         if (w_enter_flush) begin
            r_timeout <= 1'b0;
         end else if (w_set_timeout) begin
            r_timeout <= 1'b1;
         end else begin
            r_timeout <= r_timeout;
         end
         if ((w_stall != STALL_NONE) && (r_stall_cnt != CNT_SAT)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
         end else begin
            r_stall_cnt <= r_stall_cnt;
         end
      end
   end

   assign bus.stall_o      = w_stall;
   assign bus.flush_o      = rst && (r_state == ST_FLUSH);
   assign bus.ex_timeout_o = r_timeout;
   assign bus.stall_cnt_o  = r_stall_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pipe_ctrl;
   localparam int MAXS    = 16;
   localparam int FCYC    = 3;
   localparam int CW      = 5;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   bit   chk_en;
   int   burst;

   // model state: remaining flush cycles, length of current EX stall run, load in EX
   int   m_flush_left;
   int   m_ex_run;
   int   m_cnt;
   bit   m_ld_v;
   int   m_ld_wd;
   bit   m_timeout;

   pipe_ctrl_if #(.STALL_CNT_W(CW)) bus ();

   pipe_ctrl #(.MAX_EX_STALL(MAXS), .FLUSH_CYC(FCYC), .STALL_CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [5:0] exp_stall();
      bit lu;
      if (!rst) return 6'b000000;
      if (m_flush_left > 0) return 6'b000000;
      if (bus.ex_stallreq_i) return 6'b001111;
      lu = m_ld_v && ((bus.id_reg1_read_i && int'(bus.id_reg1_addr_i) == m_ld_wd) ||
                      (bus.id_reg2_read_i && int'(bus.id_reg2_addr_i) == m_ld_wd));
      return lu ? 6'b000111 : 6'b000000;
   endfunction

   task automatic model_step();
      logic [5:0] s;
      s = exp_stall();
      if (!rst) begin
         m_flush_left = 0; m_ex_run = 0; m_cnt = 0;
         m_ld_v = 1'b0; m_ld_wd = 0; m_timeout = 1'b0;
      end else begin
         if (s != 6'b000000 && m_cnt < CNT_MAX) m_cnt++;
         if (m_flush_left > 0) begin
            m_flush_left--;
            m_ld_v   = 1'b0;
            m_ex_run = 0;
         end else begin
            if (!s[2]) begin
               m_ld_v  = bus.id_is_load_i && bus.id_wreg_i && (bus.id_wd_i != 5'd0);
               m_ld_wd = int'(bus.id_wd_i);
            end else if (!s[3]) begin
               m_ld_v = 1'b0;
            end
            if (bus.flush_req_i) begin
               m_flush_left = FCYC;
               m_timeout    = 1'b0;
               m_ex_run     = 0;
            end else if (bus.ex_stallreq_i) begin
               m_ex_run = (m_ex_run + 1 > MAXS) ? MAXS : m_ex_run + 1;
               if (m_ex_run == MAXS) m_timeout = 1'b1;
            end else begin
               m_ex_run = 0;
            end
         end
      end
   endtask

   initial begin : model_proc
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   initial begin : cmp_proc
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("stall_o",      32'(bus.stall_o),      32'(exp_stall()));
            check("flush_o",      32'(bus.flush_o),      32'(rst && (m_flush_left > 0)));
            check("ex_timeout_o", 32'(bus.ex_timeout_o), 32'(m_timeout));
            check("stall_cnt_o",  32'(bus.stall_cnt_o),  32'(m_cnt));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input bit ld, input bit wr, input int wd,
                         input bit r1, input int a1, input bit r2, input int a2);
      bus.id_is_load_i   = ld;
      bus.id_wreg_i      = wr;
      bus.id_wd_i        = 5'(wd);
      bus.id_reg1_read_i = r1;
      bus.id_reg1_addr_i = 5'(a1);
      bus.id_reg2_read_i = r2;
      bus.id_reg2_addr_i = 5'(a2);
   endtask

   task automatic do_reset();
      set_id(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
      bus.ex_stallreq_i = 1'b0;
      bus.flush_req_i   = 1'b0;
      rst = 1'b0;
      cyc();
      rst = 1'b1;
   endtask

   initial begin : stim
      total = 0; bad = 0; chk_en = 1'b0; burst = 0;
      m_flush_left = 0; m_ex_run = 0; m_cnt = 0;
      m_ld_v = 1'b0; m_ld_wd = 0; m_timeout = 1'b0;
      rst = 1'b0;
      set_id(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
      bus.ex_stallreq_i = 1'b0;
      bus.flush_req_i   = 1'b0;
      cyc(); cyc();
      chk_en = 1'b1;
      bus.ex_stallreq_i = 1'b1;
      @(negedge clk);
      check("rst stall forced", 32'(bus.stall_o), 32'h0);
      check("rst cnt", 32'(bus.stall_cnt_o), 32'h0);
      check("rst timeout", 32'(bus.ex_timeout_o), 32'h0);

      // T1: load r3, dependent read on port 1
      do_reset();
      set_id(1'b1, 1'b1, 3, 1'b0, 0, 1'b0, 0);
      @(negedge clk); check("T1 pre", 32'(bus.stall_o), 32'h0);
      cyc();
      set_id(1'b0, 1'b0, 0, 1'b1, 3, 1'b0, 0);
      @(negedge clk); check("T1 stall", 32'(bus.stall_o), 32'b000111);
      cyc();
      @(negedge clk); check("T1 clear", 32'(bus.stall_o), 32'h0);
      check("T1 cnt", 32'(bus.stall_cnt_o), 32'd1);
      cyc();

      // T2: load to r0 never hazards
      do_reset();
      set_id(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 0);
      cyc();
      set_id(1'b0, 1'b0, 0, 1'b1, 0, 1'b1, 0);
      @(negedge clk); check("T2 r0", 32'(bus.stall_o), 32'h0);
      cyc();

      // T3: EX stall overlaps a load-use on port 2
      do_reset();
      set_id(1'b1, 1'b1, 5, 1'b0, 0, 1'b0, 0);
      cyc();
      set_id(1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 5);
      bus.ex_stallreq_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); check("T3 ex", 32'(bus.stall_o), 32'b001111);
         cyc();
      end
      bus.ex_stallreq_i = 1'b0;
      @(negedge clk); check("T3 lu", 32'(bus.stall_o), 32'b000111);
      cyc();
      @(negedge clk); check("T3 done", 32'(bus.stall_o), 32'h0);
      check("T3 cnt", 32'(bus.stall_cnt_o), 32'd6);
      cyc();

      // T4: timeout after 16 stall cycles, cleared by flush; EX request ignored during flush
      do_reset();
      bus.ex_stallreq_i = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk); check("T4 timeout", 32'(bus.ex_timeout_o), (i >= 17) ? 32'd1 : 32'd0);
         cyc();
      end
      bus.flush_req_i = 1'b1;
      @(negedge clk); check("T4 tmo held", 32'(bus.ex_timeout_o), 32'd1);
      check("T4 stall+flushreq", 32'(bus.stall_o), 32'b001111);
      cyc();
      bus.flush_req_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); check("T4 flush_o", 32'(bus.flush_o), 32'd1);
         check("T4 flush stall", 32'(bus.stall_o), 32'h0);
         check("T4 tmo cleared", 32'(bus.ex_timeout_o), 32'd0);
         cyc();
      end
      @(negedge clk); check("T4 flush end", 32'(bus.flush_o), 32'd0);
      check("T4 ex again", 32'(bus.stall_o), 32'b001111);
      cyc();
      bus.ex_stallreq_i = 1'b0;

      // T5: flush kills the load in EX
      do_reset();
      set_id(1'b1, 1'b1, 2, 1'b0, 0, 1'b0, 0);
      cyc();
      bus.flush_req_i = 1'b1;
      @(negedge clk); check("T5 req cycle", 32'(bus.flush_o), 32'd0);
      cyc();
      bus.flush_req_i = 1'b0;
      set_id(1'b0, 1'b0, 0, 1'b1, 2, 1'b0, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); check("T5 flush_o", 32'(bus.flush_o), 32'd1);
         check("T5 stall", 32'(bus.stall_o), 32'h0);
         cyc();
      end
      @(negedge clk); check("T5 after", 32'(bus.flush_o), 32'd0);
      check("T5 no lu", 32'(bus.stall_o), 32'h0);
      cyc();

      // T6: reset in the middle of an EX stall
      do_reset();
      bus.ex_stallreq_i = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
      @(negedge clk); check("T6 rst stall", 32'(bus.stall_o), 32'h0);
      cyc();
      rst = 1'b1;
      bus.ex_stallreq_i = 1'b0;
      @(negedge clk); check("T6 cnt", 32'(bus.stall_cnt_o), 32'd0);
      check("T6 tmo", 32'(bus.ex_timeout_o), 32'd0);
      check("T6 flush", 32'(bus.flush_o), 32'd0);
      cyc();

      // randomized traffic, small register range to provoke hazards
      for (int n = 0; n < 4000; n++) begin
         rst = ($urandom_range(0, 79) != 0);
         if (burst > 0) begin
            bus.ex_stallreq_i = 1'b1;
            burst--;
         end else if ($urandom_range(0, 9) == 0) begin
            bus.ex_stallreq_i = 1'b1;
            burst = $urandom_range(0, 21);
         end else begin
            bus.ex_stallreq_i = 1'b0;
         end
         bus.flush_req_i = ($urandom_range(0, 39) == 0);
         set_id(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), $urandom_range(0, 3));
         cyc();
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
